// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Optional build macro: DATA_MEMORY_ARBITER_CORE_PRIORITY_EN.
package data_memory_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic PORT_CORE   = 1'b0;
   localparam logic PORT_LOADER = 1'b1;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   function automatic logic [1:0] port_onehot(input logic p);
      return p ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/dmem_rr_picker.sv
// Winner select for the two requesters: round-robin, or fixed core
// priority when DATA_MEMORY_ARBITER_CORE_PRIORITY_EN is defined.
module dmem_rr_picker
   import data_memory_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       winner,
   output logic       any
);

`ifdef DATA_MEMORY_ARBITER_CORE_PRIORITY_EN
   logic unused_last;
   assign unused_last = last;
`endif

   always_comb begin
      any    = |req;
      winner = PORT_CORE;
      case (req)
         2'b10: winner = PORT_LOADER;
`ifdef DATA_MEMORY_ARBITER_CORE_PRIORITY_EN
         2'b11: winner = PORT_CORE;
`else
         2'b11: winner = ~last;
`endif
         default: winner = PORT_CORE;
      endcase
   end

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-port data-memory arbiter: IDLE -> ACCESS -> DONE, one access per 3 cycles.
// Build macro DATA_MEMORY_ARBITER_CORE_PRIORITY_EN selects fixed core priority.
module data_memory_arbiter
   import data_memory_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                pll_1_200MHz,
   input  logic                system_reset,
   input  logic [1:0]          req_i,
   input  logic [1:0]          we_i,
   input  logic [2*ADDR_W-1:0] addr_i,
   input  logic [2*DATA_W-1:0] wdata_i,
   output logic [1:0]          done_o,
   output logic [DATA_W-1:0]   rdata_o,
   output logic                busy_o,
   output logic                mem_read,
   output logic                mem_write,
   output logic [ADDR_W-1:0]   address,
   output logic [DATA_W-1:0]   write_data,
   input  logic [DATA_W-1:0]   read_data
);

   state_t              state;
   state_t              state_nx;
   logic                lat_we;
   logic                lat_win;
   logic                last;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wdata;
   logic [DATA_W-1:0]   rdata;
   logic                pick;
   logic                any;

   dmem_rr_picker u_pick (
      .req    (req_i),
      .last   (last),
      .winner (pick),
      .any    (any)
   );

   always_ff @(posedge pll_1_200MHz or posedge system_reset) begin
      if (system_reset) state <= IDLE;
      else              state <= state_nx;
   end

   always_comb begin
      state_nx = IDLE;
      case (state)
         IDLE:    state_nx = any ? ACCESS : IDLE;
         ACCESS:  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Request latch and last-winner only move on the IDLE -> ACCESS edge.
   always_ff @(posedge pll_1_200MHz or posedge system_reset) begin
      if (system_reset) begin
         lat_we    <= 1'b0;
         lat_win   <= PORT_CORE;
         lat_addr  <= '0;
         lat_wdata <= '0;
         last      <= PORT_LOADER;
         rdata     <= '0;
      end else begin
         if (state == IDLE && any) begin
            lat_we    <= we_i[pick];
            lat_win   <= pick;
            lat_addr  <= pick ? addr_i[2*ADDR_W-1:ADDR_W]
                              : addr_i[ADDR_W-1:0];
            lat_wdata <= pick ? wdata_i[2*DATA_W-1:DATA_W]
                              : wdata_i[DATA_W-1:0];
            last      <= pick;
         end
         if (state == ACCESS && !lat_we) rdata <= read_data;
      end
   end

   always_comb begin
      done_o     = 2'b00;
      busy_o     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      address    = '0;
      write_data = '0;
      case (state)
         ACCESS: begin
            busy_o     = 1'b1;
            mem_write  = lat_we;
            mem_read   = ~lat_we;
            address    = lat_addr;
            write_data = lat_wdata;
         end
         DONE: begin
            busy_o = 1'b1;
            done_o = port_onehot(lat_win);
         end
         default: ;
      endcase
   end

   assign rdata_o = rdata;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a completion scoreboard.
module tb_data_memory_arbiter;

   logic        clk = 1'b0;
   logic        system_reset;
   logic [1:0]  req;
   logic [1:0]  we;
   logic [31:0] a0, a1, d0, d1;
   logic [63:0] addr_i;
   logic [63:0] wdata_i;
   logic [1:0]  done_o;
   logic [31:0] rdata_o;
   logic        busy_o;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;

   typedef struct {
      logic [1:0]  done;
      logic [31:0] rd;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mem     [0:255];
   logic [31:0] ref_mem [0:255];
   logic [31:0] model_rd;
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;

   assign addr_i    = {a1, a0};
   assign wdata_i   = {d1, d0};
   assign read_data = mem[address[7:0]];

   always #5 clk = ~clk;

   data_memory_arbiter dut (
      .pll_1_200MHz (clk),
      .system_reset (system_reset),
      .req_i        (req),
      .we_i         (we),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .done_o       (done_o),
      .rdata_o      (rdata_o),
      .busy_o       (busy_o),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .address      (address),
      .write_data   (write_data),
      .read_data    (read_data)
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_write) mem[address[7:0]] <= write_data;
   end

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every done pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (!system_reset && done_o != 2'b00) begin
         if (sb.size() == 0) begin
            check("unexpected_done", {62'd0, done_o}, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_done", {62'd0, done_o}, {62'd0, e.done});
            check("sb_rdata", {32'd0, rdata_o}, {32'd0, e.rd});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int budget, output int at);
      logic ok;
      ok = 1'b0;
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done_o != 2'b00) begin
            ok = 1'b1;
            at = cyc;
            break;
         end
      end
      check("done_seen", {63'd0, ok}, 64'd1);
   endtask

   task automatic drive(input logic p, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
      if (p) begin
         a1 = a; d1 = d; we[1] = w; req[1] = 1'b1;
      end else begin
         a0 = a; d0 = d; we[0] = w; req[0] = 1'b1;
      end
   endtask

   // Called #1 after an edge with the DUT in IDLE; returns likewise.
   task automatic single(input logic p, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
      exp_t        e;
      logic [31:0] prev;
      prev = model_rd;
      if (w) ref_mem[a[7:0]] = d;
      else   model_rd = ref_mem[a[7:0]];
      e.done = p ? 2'b10 : 2'b01;
      e.rd   = model_rd;
      drive(p, w, a, d);
      sb.push_back(e);
      tick();
      check("acc_write", {63'd0, mem_write}, {63'd0, w});
      check("acc_read", {63'd0, mem_read}, {63'd0, ~w});
      check("acc_addr", {32'd0, address}, {32'd0, a});
      if (w) check("acc_wdata", {32'd0, write_data}, {32'd0, d});
      check("acc_busy", {63'd0, busy_o}, 64'd1);
      check("acc_rdata_hold", {32'd0, rdata_o}, {32'd0, prev});
      check("acc_done_low", {62'd0, done_o}, 64'd0);
      tick();
      check("done_val", {62'd0, done_o}, {62'd0, e.done});
      check("done_rdata", {32'd0, rdata_o}, {32'd0, model_rd});
      check("done_strobes", {62'd0, mem_read, mem_write}, 64'd0);
      check("done_addr", {32'd0, address}, 64'd0);
      req = 2'b00;
      tick();
      check("idle_busy", {63'd0, busy_o}, 64'd0);
      check("idle_done", {62'd0, done_o}, 64'd0);
      check("idle_rdata", {32'd0, rdata_o}, {32'd0, model_rd});
   endtask

   initial begin
      exp_t        e;
      int          at;
      int          prev_at;
      logic        p;
      logic [31:0] v;

      for (int i = 0; i < 256; i++) begin
         mem[i]     = 32'd0;
         ref_mem[i] = 32'd0;
      end
      model_rd = 32'd0;
      system_reset = 1'b1;
      req = 2'b00; we = 2'b00;
      a0 = '0; a1 = '0; d0 = '0; d1 = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", {63'd0, busy_o}, 64'd0);
      check("rst_done", {62'd0, done_o}, 64'd0);
      check("rst_strobes", {62'd0, mem_read, mem_write}, 64'd0);
      check("rst_rdata", {32'd0, rdata_o}, 64'd0);
      check("rst_addr", {32'd0, address}, 64'd0);
      system_reset = 1'b0;
      tick();

      // Store then load of 0x10, then store keeps rdata_o
      single(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      single(1'b1, 1'b0, 32'h10, 32'h0);
      single(1'b0, 1'b1, 32'h20, 32'h12345678);
      single(1'b1, 1'b0, 32'h20, 32'h0);
      single(1'b0, 1'b1, 32'h30, 32'hAAAA5555);
      check("store_keeps_rdata", {32'd0, rdata_o}, 64'h12345678);

      // Fresh reset, then both ports request continuously
      system_reset = 1'b1;
      tick();
      check("rst2_rdata", {32'd0, rdata_o}, 64'd0);
      system_reset = 1'b0;
      model_rd = 32'd0;
      tick();
      drive(1'b0, 1'b0, 32'h10, 32'h0);
      drive(1'b1, 1'b0, 32'h20, 32'h0);
      for (int k = 0; k < 4; k++) begin
`ifdef DATA_MEMORY_ARBITER_CORE_PRIORITY_EN
         p = 1'b0;
`else
         p = k[0];
`endif
         e.done = p ? 2'b10 : 2'b01;
         e.rd   = p ? ref_mem[8'h20] : ref_mem[8'h10];
         sb.push_back(e);
      end
      prev_at = 0;
      for (int k = 0; k < 4; k++) begin
         wait_done(6, at);
         if (k > 0) check("tie_gap", at - prev_at, 64'd3);
         prev_at = at;
      end
      v = rdata_o;
      req = 2'b00;
`ifdef DATA_MEMORY_ARBITER_CORE_PRIORITY_EN
      model_rd = ref_mem[8'h10];
`else
      model_rd = ref_mem[8'h20];
`endif
      check("tie_last_rdata", {32'd0, v}, {32'd0, model_rd});
      tick();

      // Request raised during ACCESS is held off until IDLE
      ref_mem[8'h40] = 32'h0BADF00D;
      e.done = 2'b01;
      e.rd   = model_rd;
      sb.push_back(e);
      drive(1'b0, 1'b1, 32'h40, 32'h0BADF00D);
      tick();
      drive(1'b1, 1'b0, 32'h40, 32'h0);
      check("late_addr", {32'd0, address}, 64'h40);
      check("late_write", {63'd0, mem_write}, 64'd1);
      tick();
      check("late_done0", {62'd0, done_o}, 64'h1);
      prev_at = cyc;
      req[0] = 1'b0;
      e.done = 2'b10;
      e.rd   = 32'h0BADF00D;
      sb.push_back(e);
      tick();
      check("late_idle_strobe", {62'd0, mem_read, mem_write}, 64'd0);
      wait_done(6, at);
      check("late_gap", at - prev_at, 64'd3);
      req = 2'b00;
      model_rd = 32'h0BADF00D;
      tick();
      tick();

      // Reset in the middle of ACCESS
      drive(1'b0, 1'b0, 32'h20, 32'h0);
      drive(1'b1, 1'b0, 32'h10, 32'h0);
      tick();
      check("abort_read_pre", {63'd0, mem_read}, 64'd1);
      #2;
      system_reset = 1'b1;
      #1;
      check("abort_read", {63'd0, mem_read}, 64'd0);
      check("abort_addr", {32'd0, address}, 64'd0);
      check("abort_busy", {63'd0, busy_o}, 64'd0);
      check("abort_done", {62'd0, done_o}, 64'd0);
      check("abort_rdata", {32'd0, rdata_o}, 64'd0);
      @(negedge clk);
      system_reset = 1'b0;
      e.done = 2'b01;
      e.rd   = ref_mem[8'h20];
      sb.push_back(e);
      wait_done(5, at);
      check("abort_winner", {62'd0, done_o}, 64'h1);
      req = 2'b00;
      tick();
      tick();
      check("sb_empty", sb.size(), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/data_memory_arbiter.md
DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, address width in bits.
REQ-002 Parameter: DATA_W, default 32, data width in bits.
REQ-003 pll_1_200MHz  in  1  sole clock; all state updates on its rising edge.
REQ-004 system_reset  in  1  reset; asynchronous, active-high.
REQ-005 req_i  in  2  per-port request level; bit 0 = core, bit 1 = loader/debug.
REQ-006 we_i  in  2  per-port write enable (1 = store, 0 = load).
REQ-007 addr_i  in  2*ADDR_W  per-port word address; port n in slice n.
REQ-008 wdata_i  in  2*DATA_W  per-port store data; port n in slice n.
REQ-009 done_o  out  2  one-hot, one-cycle completion pulse to the winning port.
REQ-010 rdata_o  out  DATA_W  load data, valid only when done_o is nonzero and the access was a load.
REQ-011 busy_o  out  1  high in ACCESS and DONE.
REQ-012 mem_read, mem_write  out  1 each  data-memory strobes.
REQ-013 address, write_data  out  ADDR_W / DATA_W  data-memory address and store data.
REQ-014 read_data  in  DATA_W  data-memory combinational read output.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCESS, DONE.
REQ-016 IDLE: if any req_i bit is high, pick a winner, latch its we/addr/wdata and the winner index, then go to ACCESS; otherwise stay in IDLE.
REQ-017 ACCESS: for exactly one cycle, drive address and write_data from the latch; drive mem_write=we or mem_read=~we; capture read_data into rdata_o on a load; go to DONE.
REQ-018 DONE: pulse done_o[winner] for one cycle; rdata_o holds the captured value; return to IDLE.
REQ-019 Timing: request sampled at edge T gives memory strobe in cycle T+1 and done_o in cycle T+2; peak throughput is one access per 3 cycles.
REQ-020 req_i and the per-port data inputs SHALL be ignored in ACCESS and DONE.
REQ-021 A requester SHALL hold its inputs stable until done_o; req_i still high at the first IDLE edge after DONE counts as a new request.
REQ-022 Arbitration is round-robin: with one request, that port wins; with both, the port that did not win last wins.
REQ-023 The last-winner register SHALL update only on entry to ACCESS.
REQ-024 Outside ACCESS: mem_read=0, mem_write=0, address=0, write_data=0.
REQ-025 rdata_o SHALL retain its value after DONE until the next load completes; a store SHALL leave it unchanged.

Reset
REQ-026 On system_reset, immediately and asynchronously: state=IDLE, done_o=0, busy_o=0, mem strobes=0, rdata_o=0, latch=0, last-winner=port 1 (so port 0 wins the first tie).
REQ-027 Reset asserted in ACCESS or DONE SHALL abort the access with no done_o pulse; the requester re-issues after reset.

Configuration
REQ-028 Macro DATA_MEMORY_ARBITER_CORE_PRIORITY_EN: when defined, arbitration is fixed priority and port 0 always wins a tie.
REQ-029 When the macro is undefined, arbitration is round-robin per REQ-022.
REQ-030 Ports and timing SHALL be identical in both builds.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (IDLE, ACCESS, DONE), port index constants (PORT_CORE=0, PORT_LOADER=1) and the default widths.
REQ-032 The winner-select logic SHALL be one sub-module, dmem_rr_picker, with inputs req[1:0] and last; outputs winner and any.

Verification
REQ-033 Reset, then port 0 store to addr 0x10 with data 0xDEADBEEF: mem_write=1 with address 0x10 in cycle T+1; done_o=01 in cycle T+2.
REQ-034 Port 1 load from 0x10 with memory returning 0xDEADBEEF: mem_read=1 in cycle T+1; done_o=10 and rdata_o=0xDEADBEEF in cycle T+2.
REQ-035 Both ports request continuously after reset: grant order 0,1,0,1; done pulses every 3 cycles (port 0 always wins with the macro defined).
REQ-036 A request raised during ACCESS or DONE: no effect until IDLE; served on the next IDLE edge.
REQ-037 system_reset asserted mid-ACCESS: strobes drop in the same cycle, no done_o pulse, rdata_o=0, and the next tie goes to port 0.
REQ-038 A store following a load of 0x12345678: rdata_o stays 0x12345678 throughout the store.
